// File: rtl/odd_buf_pkg.sv
// Shared constants for the odd-sample buffer slice.
//   DEF_WIDTH / DEF_DEPTH / DEF_CNT_W : default sample width, FIFO depth, error-counter width
//   ptr_w()                           : pointer width for a given depth
//   CNT_MAX                           : saturation value of the default-width error counter
package odd_buf_pkg;

    localparam int unsigned DEF_WIDTH = 7;
    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_CNT_W = 8;

    localparam int unsigned CNT_MAX = (2 ** DEF_CNT_W) - 1;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/odd_buf_fifo_mem.sv
// DEPTH x WIDTH register array backing the odd-sample FIFO.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : asynchronous read address
//   rdata : asynchronous read data
module odd_buf_fifo_mem #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is intentionally not reset; contents are only read when level>0.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/odd_sample_buffer.sv
// Checks samples from the odd-forcing stage and buffers odd ones in a
// first-word-fall-through FIFO with valid/ready output.
//   clk, reset_n        : clock, asynchronous active-low reset
//   in_valid, in_data   : upstream sample strobe and sample
//   out_ready           : downstream accepts the head entry
//   ovf_clr             : synchronous clear of the overflow flag
//   out_valid, out_data : FIFO not empty / head entry (0 when empty)
//   level               : number of stored entries, 0..DEPTH
//   err_cnt             : saturating count of even samples received
//   overflow            : sticky, an odd sample was dropped because FIFO was full
module odd_sample_buffer
    import odd_buf_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    out_ready,
    input  logic                    ovf_clr,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [ptr_w(DEPTH):0]   level,
    output logic [CNT_W-1:0]        err_cnt,
    output logic                    overflow
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             ovf_q, ovf_d;

    logic             not_empty;
    logic             full;
    logic             is_even;
    logic             is_odd;
    logic             push;
    logic             pop;
    logic             ovf_event;
    logic [WIDTH-1:0] rdata;

    assign not_empty = (level_q != '0);
    assign full      = (level_q == FULL_LVL);
    assign is_even   = in_valid & ~in_data[0];
    assign is_odd    = in_valid &  in_data[0];
    assign pop       = not_empty & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = is_odd & (~full | pop);
    assign ovf_event = is_odd & full & ~pop;

    odd_buf_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        err_cnt_d = err_cnt_q;
        ovf_d     = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        if (is_even && (err_cnt_q != CNT_SAT)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        // Set has priority over clear.
        if (ovf_event) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            err_cnt_q <= err_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid = not_empty;
    assign out_data  = not_empty ? rdata : '0;
    assign level     = level_q;
    assign err_cnt   = err_cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_odd_sample_buffer.sv
module tb_odd_sample_buffer;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [6:0] in_data;
    logic       out_ready;
    logic       ovf_clr;

    logic       out_valid, out_valid2;
    logic [6:0] out_data, out_data2;
    logic [2:0] level, level2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;
    logic       overflow, overflow2;

    odd_sample_buffer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .ovf_clr   (ovf_clr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (level),
        .err_cnt   (err_cnt),
        .overflow  (overflow)
    );

    odd_sample_buffer #(.WIDTH(7), .DEPTH(4), .CNT_W(2)) dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .ovf_clr   (ovf_clr),
        .out_valid (out_valid2),
        .out_data  (out_data2),
        .level     (level2),
        .err_cnt   (err_cnt2),
        .overflow  (overflow2)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of accepted samples plus scalar flags.
    int unsigned q[$];
    int unsigned m_err;
    int unsigned m_err2;
    bit          m_ovf;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned head();
        return (q.size() > 0) ? q[0] : 0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".level"},     32'(level),     32'(q.size()));
        check({tag, ".valid"},     32'(out_valid), 32'(q.size() > 0));
        check({tag, ".data"},      32'(out_data),  head());
        check({tag, ".err"},       32'(err_cnt),   m_err);
        check({tag, ".ovf"},       32'(overflow),  32'(m_ovf));
        check({tag, ".level2"},    32'(level2),    32'(q.size()));
        check({tag, ".valid2"},    32'(out_valid2), 32'(q.size() > 0));
        check({tag, ".data2"},     32'(out_data2), head());
        check({tag, ".err2"},      32'(err_cnt2),  m_err2);
        check({tag, ".ovf2"},      32'(overflow2), 32'(m_ovf));
    endtask

    function automatic void model_reset();
        q.delete();
        m_err  = 0;
        m_err2 = 0;
        m_ovf  = 1'b0;
    endfunction

    // One clock: drive at negedge, check outputs just before the edge (no
    // bypass from inputs), apply the model at the edge, check after it.
    task automatic cycle(input logic v, input logic [6:0] d, input logic rdy, input logic clr,
                         input string tag);
        bit popped;
        bit ovf_ev;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        ovf_clr   = clr;
        #1;
        check({tag, ".pre_valid"}, 32'(out_valid), 32'(q.size() > 0));
        check({tag, ".pre_data"},  32'(out_data),  head());
        @(posedge clk);
        popped = (q.size() > 0) && rdy;
        ovf_ev = 1'b0;
        if (popped) void'(q.pop_front());
        if (v) begin
            if (d[0] == 1'b0) begin
                if (m_err  < 255) m_err++;
                if (m_err2 < 3)   m_err2++;
            end else if (q.size() < DEPTH) begin
                q.push_back(int'(d));
            end else begin
                ovf_ev = 1'b1;
            end
        end
        if (ovf_ev)    m_ovf = 1'b1;
        else if (clr)  m_ovf = 1'b0;
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, 7'd0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Basic push then drain.
        cycle(1'b1, 7'd1, 1'b0, 1'b0, "push1");
        cycle(1'b1, 7'd3, 1'b0, 1'b0, "push3");
        cycle(1'b1, 7'd5, 1'b0, 1'b0, "push5");
        for (int i = 0; i < 3; i++) cycle(1'b0, 7'd0, 1'b1, 1'b0, "drain");

        // Parity errors, counter saturation on the narrow instance.
        cycle(1'b1, 7'd4,   1'b0, 1'b0, "even4");
        cycle(1'b1, 7'd126, 1'b0, 1'b0, "even126");
        cycle(1'b1, 7'd0,   1'b0, 1'b0, "even0");
        for (int i = 0; i < 5; i++) cycle(1'b1, 7'd2, 1'b0, 1'b0, "even_sat");

        // Overflow and its clear.
        cycle(1'b1, 7'd9,  1'b0, 1'b0, "fill");
        cycle(1'b1, 7'd11, 1'b0, 1'b0, "fill");
        cycle(1'b1, 7'd13, 1'b0, 1'b0, "fill");
        cycle(1'b1, 7'd15, 1'b0, 1'b0, "fill");
        cycle(1'b1, 7'd17, 1'b0, 1'b0, "ovf17");
        cycle(1'b1, 7'd8,  1'b0, 1'b0, "even_full");
        cycle(1'b0, 7'd0,  1'b0, 1'b1, "ovf_clr");
        cycle(1'b1, 7'd21, 1'b0, 1'b1, "ovf_set_wins");
        cycle(1'b0, 7'd0,  1'b0, 1'b1, "ovf_clr2");

        // Push with pop at full, then drain.
        cycle(1'b1, 7'd19, 1'b1, 1'b0, "full_pushpop");
        for (int i = 0; i < 5; i++) cycle(1'b0, 7'd0, 1'b1, 1'b0, "drain2");

        // Streaming push+pop, pointer wrap.
        for (int i = 0; i < 10; i++) cycle(1'b1, 7'(2 * i + 31), 1'b1, 1'b0, "stream");
        idle("stream_end");
        cycle(1'b0, 7'd0, 1'b1, 1'b0, "stream_drain");

        // Asynchronous reset mid-stream.
        cycle(1'b1, 7'd41, 1'b0, 1'b0, "pre_rst");
        cycle(1'b1, 7'd43, 1'b0, 1'b0, "pre_rst");
        cycle(1'b1, 7'd6,  1'b0, 1'b0, "pre_rst_even");
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        reset_n = 1'b1;
        cycle(1'b1, 7'd45, 1'b0, 1'b0, "post_rst");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [6:0] d;
            d = 7'($urandom);
            if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
            cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
